pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, flow-controlled successor to the fixed inter-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque DATA_W-bit payload (packed control + datapath fields) between two pipeline stages with a valid/ready handshake.
- A 2-entry skid buffer makes in_ready a pure register output, so back-pressure does not form a combinational path across stages.
- Provides a squash/flush input for branch/jump recovery, a programmable bubble value, and a saturating stall counter for performance debug.

Parameters:
DATA_W, 64, payload width in bits (≥1)
NOP_VAL, '0, DATA_W-bit payload loaded into every emptied or flushed entry (bubble encoding)
CNT_W, 16, width of the stall counter (≥1)

Ports:
CLK  in  1  rising-edge clock
RST  in  1  synchronous reset, active-high
flush  in  1  squash all held entries and any beat arriving this cycle
in_valid  in  1  upstream beat present
in_ready  out  1  stage can accept a beat; registered output
in_data  in  DATA_W  upstream payload
out_valid  out  1  beat presented downstream
out_ready  in  1  downstream accepts
out_data  out  DATA_W  payload of the main entry
occupancy  out  2  entries held: 0, 1 or 2
stall_cnt  out  CNT_W  cycles with out_valid=1 && out_ready=0, saturating

Behaviour:
- Handshake definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register.
- State machine: EMPTY (occupancy 0), ONE (1), TWO (2).
- Output decode from state only: out_valid = (state != EMPTY); in_ready = (state != TWO). Both are registered.
- Reset: synchronous; RST=1 at the clock edge sets state=EMPTY, main=skid=NOP_VAL, stall_cnt=0. Resulting outputs: out_valid=0, in_ready=1, occupancy=0, out_data=NOP_VAL.
- Priority, highest first: RST > flush > normal handshake.
- flush=1 (RST=0):
  - state goes to EMPTY; main=skid=NOP_VAL.
  - A beat with in_fire that same cycle is discarded.
  - An out_fire that same cycle is still a completed transfer downstream; the block drops it internally.
  - stall_cnt is not cleared by flush.
- EMPTY:
  - in_fire: main <= in_data, go to ONE.
  - Otherwise hold.
- ONE:
  - in_fire & out_fire: main <= in_data, stay in ONE (full throughput).
  - in_fire only: skid <= in_data, go to TWO.
  - out_fire only: main <= NOP_VAL, go to EMPTY.
  - Neither: hold.
- TWO:
  - in_ready=0, so no in_fire is possible.
  - out_fire: main <= skid, skid <= NOP_VAL, go to ONE.
  - Otherwise hold.
- Latency and throughput: a beat accepted at edge N appears on out_data with out_valid=1 after edge N (1 cycle). Sustained throughput is 1 beat/cycle when out_ready=1.
- Ordering: strict FIFO; beats are never duplicated or reordered.
- Stability: out_data stays stable while out_valid=1 && out_ready=0.
- Upstream rule: a beat offered while in_ready=0 is not taken, and upstream must hold it.
- stall_cnt: increments by 1 on each edge where out_valid=1 && out_ready=0 && flush=0. It holds at 2^CNT_W-1 (no wrap). Only RST clears it.
- Bubble behaviour: out_data equals NOP_VAL whenever state=EMPTY, so a consumer that ignores out_valid sees a NOP (matches the existing zeroed-latch bubble behaviour).
- Mid-operation RST: RST asserted in any state discards both entries with no out_fire credit.

Test Plan:
- Reset: DATA_W=8, NOP_VAL=8'hFF, RST=1 for 2 cycles then 0 -> out_valid=0, in_ready=1, occupancy=0, out_data=8'hFF, stall_cnt=0.
- Streaming: in_valid=1, out_ready=1, in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later each, occupancy stays 1, in_ready stays 1.
- Back-pressure/skid: out_ready=0, push 8'hA1 then 8'hA2 -> occupancy=2, in_ready=0, 8'hA3 is held upstream. Then out_ready=1 -> outputs A1, A2, A3 in order. stall_cnt counts exactly the stalled cycles (e.g. 3).
- Flush: occupancy=2 (B1,B2), flush=1 with in_valid=1, in_data=8'hB3 -> next cycle occupancy=0, out_valid=0, out_data=8'hFF. B3 never appears downstream; stall_cnt unchanged.
- Saturation: CNT_W=3, out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=7 and holds at 7.
- Mid-operation reset: occupancy=2, RST=1 with out_ready=1 -> next cycle all reset values. First beat pushed after RST deasserts emerges unaltered.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: flow-controlled pipeline stage register with a 2-entry skid buffer.
// Carries an opaque DATA_W-bit payload between stages over a valid/ready handshake.
// in_ready and out_valid come straight from flops, so back-pressure never forms a
// combinational path across stages.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous reset, active-high
//   flush      squash all held entries and any beat arriving this cycle
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat (registered)
//   in_data    upstream payload
//   out_valid  beat presented downstream (registered)
//   out_ready  downstream accepts
//   out_data   payload of the main entry (NOP_VAL when empty)
//   occupancy  entries held: 0, 1 or 2
//   stall_cnt  saturating count of cycles with out_valid=1 && out_ready=0
module pipe_stage_reg #(
    parameter int unsigned        DATA_W  = 64,
    parameter logic [DATA_W-1:0]  NOP_VAL = '0,
    parameter int unsigned        CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next-state and storage update; flush overrides the handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = EMPTY;
            main_d  = NOP_VAL;
            skid_d  = NOP_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (out_fire) begin
                        main_d  = NOP_VAL;
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = NOP_VAL;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_VAL;
                    skid_d  = NOP_VAL;
                end
            endcase
        end

        // Handshake outputs are decoded from the next state and registered.
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != TWO);
    end

    // Saturating stall counter; a flush cycle does not count as a stall.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_q && !out_ready && !flush && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, storage and counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= EMPTY;
            main_q      <= NOP_VAL;
            skid_q      <= NOP_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vector table, hand sequences and randomized run
// against a queue-based reference model for pipe_stage_reg (DATA_W=8, NOP=FF, CNT_W=3).
module tb_pipe_stage_reg;

    localparam int unsigned DW  = 8;
    localparam int unsigned CW  = 3;
    localparam logic [DW-1:0] NOP = 8'hFF;
    localparam int CNT_SAT = 7;

    logic          CLK = 1'b0;
    logic          RST;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_reg #(
        .DATA_W (DW),
        .NOP_VAL(NOP),
        .CNT_W  (CW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit            rst;
        bit            fl;
        bit            iv;
        logic [DW-1:0] d;
        bit            ordy;
        bit            ev;
        bit            er;
        logic [1:0]    eocc;
        logic [DW-1:0] edata;
        logic [CW-1:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit fl, bit iv, logic [DW-1:0] d, bit ordy,
                                bit ev, bit er, logic [1:0] eocc, logic [DW-1:0] edata,
                                logic [CW-1:0] ecnt);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ev = ev; v.er = er; v.eocc = eocc; v.edata = edata; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit f, input bit iv, input logic [DW-1:0] d,
                         input bit ordy);
        RST = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    endtask

    // Apply one cycle of inputs and check outputs just after the edge.
    task automatic apply_vec(input vec_t v, input int idx);
        drive(v.rst, v.fl, v.iv, v.d, v.ordy);
        @(posedge CLK);
        #1;
        check("out_valid", idx, 32'(out_valid), 32'(v.ev));
        check("in_ready",  idx, 32'(in_ready),  32'(v.er));
        check("occupancy", idx, 32'(occupancy), 32'(v.eocc));
        check("out_data",  idx, 32'(out_data),  32'(v.edata));
        check("stall_cnt", idx, 32'(stall_cnt), 32'(v.ecnt));
    endtask

    // Reference model: a bounded FIFO of beats plus a saturating stall count.
    logic [DW-1:0] mq[$];
    int            mcnt;

    task automatic rstep(input bit r, input bit f, input bit iv, input logic [DW-1:0] d,
                         input bit ordy, input int idx);
        bit mv;
        bit mr;
        drive(r, f, iv, d, ordy);
        mv = (mq.size() > 0);
        mr = (mq.size() < 2);
        check("rnd_out_valid", idx, 32'(out_valid), 32'(mv));
        check("rnd_in_ready",  idx, 32'(in_ready),  32'(mr));
        check("rnd_occupancy", idx, 32'(occupancy), 32'(mq.size()));
        check("rnd_out_data",  idx, 32'(out_data),  32'(mv ? mq[0] : NOP));
        check("rnd_stall_cnt", idx, 32'(stall_cnt), 32'(mcnt));
        if (r) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (mv && !ordy && !f && mcnt < CNT_SAT) mcnt++;
            if (f) begin
                mq.delete();
            end else begin
                if (mv && ordy) void'(mq.pop_front());
                if (iv && mr) mq.push_back(d);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset
        tbl.push_back(mk(1,0,0,8'h00,0, 0,1,2'd0,NOP,3'd0));
        tbl.push_back(mk(1,0,0,8'h00,0, 0,1,2'd0,NOP,3'd0));
        // Streaming at full rate
        tbl.push_back(mk(0,0,1,8'h01,1, 1,1,2'd1,8'h01,3'd0));
        tbl.push_back(mk(0,0,1,8'h02,1, 1,1,2'd1,8'h02,3'd0));
        tbl.push_back(mk(0,0,1,8'h03,1, 1,1,2'd1,8'h03,3'd0));
        tbl.push_back(mk(0,0,1,8'h04,1, 1,1,2'd1,8'h04,3'd0));
        tbl.push_back(mk(0,0,0,8'h00,1, 0,1,2'd0,NOP,3'd0));
        // Back-pressure into the skid entry; A3 is held upstream
        tbl.push_back(mk(0,0,1,8'hA1,0, 1,1,2'd1,8'hA1,3'd0));
        tbl.push_back(mk(0,0,1,8'hA2,0, 1,0,2'd2,8'hA1,3'd1));
        tbl.push_back(mk(0,0,1,8'hA3,0, 1,0,2'd2,8'hA1,3'd2));
        tbl.push_back(mk(0,0,1,8'hA3,0, 1,0,2'd2,8'hA1,3'd3));
        tbl.push_back(mk(0,0,1,8'hA3,1, 1,1,2'd1,8'hA2,3'd3));
        tbl.push_back(mk(0,0,1,8'hA3,1, 1,1,2'd1,8'hA3,3'd3));
        tbl.push_back(mk(0,0,0,8'h00,1, 0,1,2'd0,NOP,3'd3));
        // Flush while full, with a beat arriving the same cycle
        tbl.push_back(mk(0,0,1,8'hB1,0, 1,1,2'd1,8'hB1,3'd3));
        tbl.push_back(mk(0,0,1,8'hB2,0, 1,0,2'd2,8'hB1,3'd4));
        tbl.push_back(mk(0,1,1,8'hB3,0, 0,1,2'd0,NOP,3'd4));
        tbl.push_back(mk(0,0,0,8'h00,1, 0,1,2'd0,NOP,3'd4));
        // Saturation of the 3-bit stall counter
        tbl.push_back(mk(0,0,1,8'hC1,0, 1,1,2'd1,8'hC1,3'd4));
        for (int k = 1; k <= 10; k++) begin
            tbl.push_back(mk(0,0,0,8'h00,0, 1,1,2'd1,8'hC1,
                             CW'((4 + k > CNT_SAT) ? CNT_SAT : 4 + k)));
        end
        // Flush coinciding with an out_fire; counter survives flush, RST clears it
        tbl.push_back(mk(0,1,0,8'h00,1, 0,1,2'd0,NOP,3'd7));
        tbl.push_back(mk(1,0,0,8'h00,0, 0,1,2'd0,NOP,3'd0));

        foreach (tbl[i]) apply_vec(tbl[i], i);

        // Mid-operation reset while full and draining
        apply_vec(mk(0,0,1,8'hD1,0, 1,1,2'd1,8'hD1,3'd0), 100);
        apply_vec(mk(0,0,1,8'hD2,0, 1,0,2'd2,8'hD1,3'd1), 101);
        apply_vec(mk(1,0,1,8'hD3,1, 0,1,2'd0,NOP,3'd0),   102);
        apply_vec(mk(0,0,1,8'hD4,0, 1,1,2'd1,8'hD4,3'd0), 103);
        apply_vec(mk(0,0,0,8'h00,1, 0,1,2'd0,NOP,3'd0),   104);
        apply_vec(mk(1,0,0,8'h00,0, 0,1,2'd0,NOP,3'd0),   105);

        // Randomized run against the reference model
        mq.delete();
        mcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit f;
            bit iv;
            bit ordy;
            r    = ($urandom_range(0, 199) == 0);
            f    = ($urandom_range(0, 15) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 5);
            rstep(r, f, iv, DW'($urandom), ordy, 1000 + i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
